// File: rtl/lcd_nibble_tx.sv
// Character-LCD 4-bit write stage: sends a latched {RS,RW,D[7:0]} word as two
// E-framed nibbles, then holds busy through the command execution wait.
module lcd_nibble_tx #(
  parameter int T_SU  = 2,
  parameter int T_EW  = 12,
  parameter int T_H   = 1,
  parameter int T_GAP = 50,
  parameter int T_CMD = 2000,
  parameter int CNT_W = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [9:0] i_instr,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [3:0] o_lcd_db
);

  typedef enum logic [3:0] {
    S_IDLE, S_HI_SU, S_HI_E, S_HI_H, S_GAP,
    S_LO_SU, S_LO_E, S_LO_H, S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] C_SU  = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] C_EW  = CNT_W'(T_EW - 1);
  localparam logic [CNT_W-1:0] C_H   = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] C_GAP = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] C_CMD = CNT_W'(T_CMD - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last_cnt;
  logic             w_last;
  logic [9:0]       r_instr;
  logic [9:0]       w_instr;
  logic             w_hi_phase;
  logic             w_busy;
  logic             w_done;
  logic             w_e;
  logic             w_rs;
  logic             w_rw;
  logic [3:0]       w_db;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_last_cnt = '0;
    case (r_state)
      S_HI_SU, S_LO_SU: w_last_cnt = C_SU;
      S_HI_E,  S_LO_E:  w_last_cnt = C_EW;
      S_HI_H,  S_LO_H:  w_last_cnt = C_H;
      S_GAP:            w_last_cnt = C_GAP;
      S_WAIT:           w_last_cnt = C_CMD;
      default:          w_last_cnt = '0;
    endcase
    w_last = (r_cnt == w_last_cnt);
  end

  always_comb begin
    w_next  = r_state;
    w_instr = r_instr;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next  = S_HI_SU;
          w_instr = i_instr;
        end
      end
      S_HI_SU: if (w_last) w_next = S_HI_E;
      S_HI_E:  if (w_last) w_next = S_HI_H;
      S_HI_H:  if (w_last) w_next = S_GAP;
      S_GAP:   if (w_last) w_next = S_LO_SU;
      S_LO_SU: if (w_last) w_next = S_LO_E;
      S_LO_E:  if (w_last) w_next = S_LO_H;
      S_LO_H:  if (w_last) w_next = S_WAIT;
      S_WAIT:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered on the same edge,
  // so the pins change exactly at state boundaries with no input-to-pin path.
  always_comb begin
    w_hi_phase = (w_next == S_HI_SU) || (w_next == S_HI_E) ||
                 (w_next == S_HI_H)  || (w_next == S_GAP);
    w_busy     = (w_next != S_IDLE);
    w_done     = (r_state == S_WAIT) && w_last;
    w_e        = (w_next == S_HI_E) || (w_next == S_LO_E);
    w_rs       = w_busy & w_instr[9];
    w_rw       = w_busy & w_instr[8];
    w_db       = '0;
    if (w_busy) w_db = w_hi_phase ? w_instr[7:4] : w_instr[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the instruction latch is reset too; it is only a 10-bit register,
  // so a known value after reset costs nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_instr  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_lcd_e  <= 1'b0;
      o_lcd_rs <= 1'b0;
      o_lcd_rw <= 1'b0;
      o_lcd_db <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + 1'b1;
      r_instr  <= w_instr;
      o_busy   <= w_busy;
      o_done   <= w_done;
      o_lcd_e  <= w_e;
      o_lcd_rs <= w_rs;
      o_lcd_rw <= w_rw;
      o_lcd_db <= w_db;
    end
  end

endmodule
